gray_counter_param: RTL and testbench
=====================================

# gray_counter_param

Parametrised synchronous Gray-code counter, the successor to the fixed 3-bit Gray counter used in the P1 exercises. It adds configurable width, up/down counting, parallel load, a separate overflow-clear input and a binary mirror of the count. It sits wherever a registered Gray-coded sequence is needed, such as a FIFO pointer or a clock-domain-crossing counter.

## Interface
- WIDTH, 3, counter width in bits (2..16)
- INIT, 0, binary value loaded on reset; must be < 2^WIDTH
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset
- En  input  1  count enable
- Dir  input  1  0 = count up, 1 = count down
- Load  input  1  parallel load strobe
- LoadVal  input  WIDTH  binary value to load
- Clr  input  1  clears Overflow
- Output  output  WIDTH  registered Gray code of the count
- Count  output  WIDTH  registered binary count
- Overflow  output  1  wrap indicator; registered

## Operation
- Internal state is a WIDTH-bit binary register `bin`.
  - `Count = bin`.
  - `Output = bin ^ (bin >> 1)`, held in its own register and updated on the same edge as `bin`.
- Per-edge priority, highest first:
  1. Reset = 0: `bin` = INIT, Output = gray(INIT), Overflow = 0. All other inputs are ignored.
  2. Load = 1: `bin` = LoadVal. Overflow is unaffected by the load itself; Clr still applies this cycle. En and Dir are ignored.
  3. En = 1, Dir = 0: `bin` = `bin` + 1, modulo 2^WIDTH.
  4. En = 1, Dir = 1: `bin` = `bin` − 1, modulo 2^WIDTH.
  5. Otherwise `bin` holds.
- Wrap event: up-count from 2^WIDTH−1 to 0, or down-count from 0 to 2^WIDTH−1. A load never generates a wrap, even to or from a boundary value.
- Overflow update, evaluated when not in reset:
  - Wrap event this edge: Overflow = 1. This holds even if Clr = 1, so a wrap is never lost.
  - No wrap and Clr = 1: Overflow = 0.
  - No wrap and Clr = 0: behaviour depends on the configuration macro (see Configuration).
- Dir may change on any cycle. The next edge uses the new direction, with no dead cycle.
- Arithmetic is purely WIDTH-bit. No carry output is produced beyond the wrap event.

## Timing
- All outputs are registered with zero combinational input-to-output paths. An input change is seen at the outputs one edge later.
- Consecutive Output values differ by exactly one bit for every En step, including the wrap step.
  - A load may change multiple bits.
- Reset values:
  - Output = gray(INIT)
  - Count = INIT
  - Overflow = 0
- Reset asserted mid-count takes effect on the next rising edge and overrides Load, En and Clr asserted in the same cycle.
- Counting resumes on the first edge with Reset = 1 and En = 1.

## Configuration
- Macro: `GRAY_OVF_PULSE_EN`.
- Defined (pulse mode):
  - Overflow is high for exactly the one cycle following a wrap edge.
  - On any edge without a wrap it returns to 0, whatever Clr is.
- Undefined (sticky mode):
  - Overflow stays 1 after the first wrap.
  - It is cleared only by Reset or by Clr on an edge without a wrap.
  - This matches the original P1 counter behaviour.

## Test plan
WIDTH = 3, INIT = 0, sticky mode unless noted.
- Up-count sequence:
  - Stimulus: release Reset, En = 1, Dir = 0 for 8 edges.
  - Response: Output = 000, 001, 011, 010, 110, 111, 101, 100, 000. Overflow rises to 1 on the edge where Output returns to 000 and stays 1.
- Clear/wrap collision:
  - Stimulus: with Overflow = 1 and no wrap, pulse Clr.
  - Response: Overflow = 0 on the next edge.
  - Stimulus: with Count = 7, assert Clr and En together.
  - Response: Count = 0, Overflow = 1.
- Down-count with load:
  - Stimulus: Load = 1, LoadVal = 2, then Dir = 1, En = 1 for 3 edges.
  - Response: Count = 2, 1, 0, 7. Output = 011, 001, 000, 100. Overflow = 1 only after the 0→7 edge. The load edge itself leaves Overflow unchanged.
- Priority:
  - Stimulus: Load = 1, LoadVal = 5 with En = 1 in the same cycle.
  - Response: Count = 5, not 6.
  - Stimulus: Reset = 0 with Load = 1 in the same cycle.
  - Response: Count = 0, Output = 000, Overflow = 0.
- Hold:
  - Stimulus: En = 0 for 5 edges at Count = 3.
  - Response: Output stays 010 and Overflow is unchanged.
- Pulse mode (`GRAY_OVF_PULSE_EN` defined):
  - Stimulus: up-count through 7→0 and continue counting.
  - Response: Overflow = 1 for exactly one cycle, then 0.
- Width sweep:
  - Stimulus: WIDTH = 5, INIT = 0, up-count for a full cycle.
  - Response: adjacent Output values differ by one bit across all 32 steps. The wrap occurs at step 32.

Source files
------------

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter with up/down, parallel load, overflow flag and binary mirror.
// Macro GRAY_OVF_PULSE_EN: Overflow pulses for one cycle per wrap; undefined, it is sticky.
module gray_counter_param #(
  parameter int WIDTH = 3,
  parameter int INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Clr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Count,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
  localparam logic [WIDTH-1:0] MAX_BIN   = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             wrap;

  always_comb begin
    bin_d = bin_q;
    wrap  = 1'b0;
    if (Load) begin
      bin_d = LoadVal;
    end else if (En) begin
      if (!Dir) begin
        bin_d = bin_q + 1'b1;
        wrap  = (bin_q == MAX_BIN);
      end else begin
        bin_d = bin_q - 1'b1;
        wrap  = (bin_q == '0);
      end
    end
    // Gray is derived from the next binary value so both registers move on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // A wrap always wins over Clr so that no wrap is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (Clr) begin
      ovf_d = 1'b0;
    end else begin
`ifdef GRAY_OVF_PULSE_EN
      ovf_d = 1'b0;
`else
      ovf_d = ovf_q;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Count    = bin_q;
  assign Output   = gray_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: vector table on a 3-bit counter, plus
// a 5-bit full-cycle sweep and a 4-bit non-zero INIT instance.
module tb_gray_counter_param;

`ifdef GRAY_OVF_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3-bit instance signals
  logic       rst3, en3, dir3, ld3, clr3;
  logic [2:0] lv3, cnt3, gry3;
  logic       ovf3;

  // 5-bit and 4-bit instances share controls
  logic       rst5, en5, dir5, ld5, clr5;
  logic [4:0] lv5, cnt5, gry5;
  logic       ovf5;
  logic [3:0] lv4, cnt4, gry4;
  logic       ovf4;

  gray_counter_param #(.WIDTH(3), .INIT(0)) dut3 (
    .Clk(clk), .Reset(rst3), .En(en3), .Dir(dir3), .Load(ld3), .LoadVal(lv3),
    .Clr(clr3), .Output(gry3), .Count(cnt3), .Overflow(ovf3)
  );

  gray_counter_param #(.WIDTH(5), .INIT(0)) dut5 (
    .Clk(clk), .Reset(rst5), .En(en5), .Dir(dir5), .Load(ld5), .LoadVal(lv5),
    .Clr(clr5), .Output(gry5), .Count(cnt5), .Overflow(ovf5)
  );

  gray_counter_param #(.WIDTH(4), .INIT(9)) dut4 (
    .Clk(clk), .Reset(rst5), .En(en5), .Dir(dir5), .Load(ld5), .LoadVal(lv4),
    .Clr(clr5), .Output(gry4), .Count(cnt4), .Overflow(ovf4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit       rst_n, en, dir, ld, clr;
    bit [2:0] lv;
    bit [2:0] ec, eg;
    bit       eos, eop;  // expected Overflow in sticky / pulse mode
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst_n, bit en, bit dir, bit ld, bit [2:0] lv, bit clr,
                              bit [2:0] ec, bit [2:0] eg, bit eos, bit eop);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.dir = dir; v.ld = ld; v.lv = lv; v.clr = clr;
    v.ec = ec; v.eg = eg; v.eos = eos; v.eop = eop;
    return v;
  endfunction

  initial begin
    logic [4:0] exp5, prev_g5;

    //                    rst en dir ld lv clr   cnt   gray   os eop
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0, 0)); // reset
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd1, 3'b001, 0, 0)); // up-count
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd2, 3'b011, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd3, 3'b010, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd4, 3'b110, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd5, 3'b111, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd6, 3'b101, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd7, 3'b100, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'b000, 1, 1)); // wrap 7->0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 1, 0)); // sticky hold
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3'd0, 3'b000, 0, 0)); // clr
    vecs.push_back(mk(1, 0, 0, 1, 7, 0, 3'd7, 3'b100, 0, 0)); // load 7
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 3'd0, 3'b000, 1, 1)); // clr+wrap
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3'd0, 3'b000, 0, 0)); // clr
    vecs.push_back(mk(1, 1, 1, 1, 2, 0, 3'd2, 3'b011, 0, 0)); // load 2, En ignored
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'd1, 3'b001, 0, 0)); // down
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'd0, 3'b000, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'd7, 3'b100, 1, 1)); // wrap 0->7
    vecs.push_back(mk(1, 1, 0, 1, 5, 0, 3'd5, 3'b111, 1, 0)); // load beats En
    vecs.push_back(mk(1, 0, 0, 1, 3, 0, 3'd3, 3'b010, 1, 0)); // load 3
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'd3, 3'b010, 1, 0)); // hold
    vecs.push_back(mk(0, 1, 0, 1, 6, 0, 3'd0, 3'b000, 0, 0)); // reset beats load
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd1, 3'b001, 0, 0)); // resume
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'd0, 3'b000, 0, 0)); // direction flip
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'd7, 3'b100, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, 3'b000, 1, 1)); // flip, wrap up
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3'd0, 3'b000, 0, 0)); // clr
    vecs.push_back(mk(1, 0, 0, 1, 7, 0, 3'd7, 3'b100, 0, 0)); // load to max, no wrap
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 3'd0, 3'b000, 0, 0)); // load max->0, no wrap

    rst3 = 0; en3 = 0; dir3 = 0; ld3 = 0; clr3 = 0; lv3 = '0;
    rst5 = 0; en5 = 0; dir5 = 0; ld5 = 0; clr5 = 0; lv5 = '0; lv4 = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst3 = vecs[i].rst_n; en3 = vecs[i].en; dir3 = vecs[i].dir;
      ld3 = vecs[i].ld; lv3 = vecs[i].lv; clr3 = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), int'(cnt3), int'(vecs[i].ec));
      chk($sformatf("v%0d_gray", i), int'(gry3), int'(vecs[i].eg));
      chk($sformatf("v%0d_ovf", i), int'(ovf3), int'(PULSE ? vecs[i].eop : vecs[i].eos));
    end

    // Reset values of the wider instances (held in reset so far)
    chk("w5_reset_count", int'(cnt5), 0);
    chk("w5_reset_ovf", int'(ovf5), 0);
    chk("w4_reset_count", int'(cnt4), 9);
    chk("w4_reset_gray", int'(gry4), 13);
    chk("w4_reset_ovf", int'(ovf4), 0);

    // Width sweep: 32 up steps on the 5-bit instance
    @(negedge clk);
    rst5 = 1; en5 = 1; dir5 = 0;
    prev_g5 = 5'b0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      exp5 = 5'(i);
      chk($sformatf("w5_s%0d_count", i), int'(cnt5), int'(exp5));
      chk($sformatf("w5_s%0d_gray", i), int'(gry5), int'(exp5 ^ (exp5 >> 1)));
      chk($sformatf("w5_s%0d_onebit", i), $countones(gry5 ^ prev_g5), 1);
      chk($sformatf("w5_s%0d_ovf", i), int'(ovf5), (i == 32) ? 1 : 0);
      prev_g5 = gry5;
    end
    // 4-bit instance went 9 -> 9 over 32 steps, last wrap at step 23
    chk("w4_end_count", int'(cnt4), 9);
    chk("w4_end_gray", int'(gry4), 13);
    chk("w4_end_ovf", int'(ovf4), PULSE ? 0 : 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
